// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EX-stage operand-forwarding controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fwd_pkg;

  // Register-address width that the shadow entries are sized for.
  localparam int REG_ADDR_W = 5;

  // Encoding of the EX operand-mux select.
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'd0;  // take the register-file read data
  localparam fwd_sel_t FWD_WB  = 2'd1;  // take the MEM/WB output
  localparam fwd_sel_t FWD_MEM = 2'd2;  // take the EX/MEM ALU result

  // Destination information of the instruction occupying one pipeline stage.
  typedef struct packed {
    logic                  vld;  // stage holds a real instruction
    logic [REG_ADDR_W-1:0] rd;   // destination register
    logic                  rw;   // instruction writes rd
    logic                  mr;   // instruction is a load
  } shadow_entry_t;

  // True when the entry will write architectural register r.
  // x0 is hard-wired to zero, so it never counts as written.
  function automatic logic entry_writes(input shadow_entry_t e,
                                        input logic [REG_ADDR_W-1:0] r);
    return e.vld && e.rw && (e.rd == r) && (r != '0);
  endfunction

  // Operand select for one source, evaluated while the consumer is in ID.
  // The EX entry is the youngest producer, so it wins over the MEM entry.
  function automatic fwd_sel_t fwd_select(input logic                  use_s,
                                          input logic [REG_ADDR_W-1:0] r,
                                          input shadow_entry_t         ex,
                                          input shadow_entry_t         mem);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (use_s) begin
      if (entry_writes(ex, r)) begin
        sel = FWD_MEM;
      end else if (entry_writes(mem, r)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One shadow pipeline entry (EX, MEM or WB destination info).
// Latency: 1 cycle from d to q when neither held nor bubbled.
// Backpressure: hold freezes the entry; bubble loads an invalid entry instead of d.
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hold,
  input  logic          bubble,
  input  shadow_entry_t d,
  output shadow_entry_t q
);

  shadow_entry_t entry_d;
  shadow_entry_t entry_q;

  // Next entry: hold beats bubble, bubble beats a normal load.
  always_comb begin
    entry_d = d;
    if (hold) begin
      entry_d = entry_q;
    end else if (bubble) begin
      entry_d = '0;
    end
  end

  // Entry register; an all-zero entry is an invalid slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand-forward select generator with load-use stall detection and stall counter.
// Latency: forward_* registered (valid in the consumer's first EX cycle); stall and id_bypass_* are combinational.
// Backpressure: mem_stall freezes every register; stall holds ID and bubbles EX; flush bubbles EX.
// Optional feature: FWD_WB_BYPASS_EN enables the WB->ID bypass outputs for a read-first register file.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int RA_W        = REG_ADDR_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   id_valid,
  input  logic [RA_W-1:0]        id_rs1,
  input  logic [RA_W-1:0]        id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [RA_W-1:0]        id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   flush,
  input  logic                   mem_stall,
  output logic [1:0]             forward_a,
  output logic [1:0]             forward_b,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   id_bypass_rs1,
  output logic                   id_bypass_rs2
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  shadow_entry_t id_entry;
  shadow_entry_t ex_q;
  shadow_entry_t mem_q;
  shadow_entry_t wb_q;

  logic     load_use;
  logic     ex_bubble;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  fwd_sel_t                 forward_a_d;
  fwd_sel_t                 forward_a_q;
  fwd_sel_t                 forward_b_d;
  fwd_sel_t                 forward_b_q;
  logic [STALL_CNT_W-1:0]   stall_cnt_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q;

  // Pack the ID instruction's destination info into a shadow entry.
  always_comb begin
    id_entry     = '0;
    id_entry.vld = id_valid;
    id_entry.rd  = id_rd;
    id_entry.rw  = id_reg_write;
    id_entry.mr  = id_mem_read;
  end

  // Load-use hazard: a load in EX produces a source the ID instruction reads.
  // A frozen pipeline never reports a stall, so it cannot be double counted.
  always_comb begin
    load_use = id_valid && ex_q.mr &&
               ((id_use_rs1 && entry_writes(ex_q, id_rs1)) ||
                (id_use_rs2 && entry_writes(ex_q, id_rs2)));
    if (mem_stall) begin
      load_use = 1'b0;
    end
  end

  assign stall     = load_use;
  assign ex_bubble = flush || load_use;

  // EX takes the ID instruction, or a bubble on redirect or load-use.
  fwd_stage_reg u_ex_stage (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (mem_stall),
    .bubble  (ex_bubble),
    .d       (id_entry),
    .q       (ex_q)
  );

  // MEM always follows EX unless frozen.
  fwd_stage_reg u_mem_stage (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (mem_stall),
    .bubble  (1'b0),
    .d       (ex_q),
    .q       (mem_q)
  );

  // WB always follows MEM unless frozen.
  fwd_stage_reg u_wb_stage (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (mem_stall),
    .bubble  (1'b0),
    .d       (mem_q),
    .q       (wb_q)
  );

  // Selects seen from ID: whatever sits in EX now is in MEM when the consumer reaches EX.
  always_comb begin
    sel_a = fwd_select(id_use_rs1, id_rs1, ex_q, mem_q);
    sel_b = fwd_select(id_use_rs2, id_rs2, ex_q, mem_q);
  end

  // Next select and counter values under the freeze > bubble > advance priority.
  always_comb begin
    forward_a_d = sel_a;
    forward_b_d = sel_b;
    stall_cnt_d = stall_cnt_q;
    if (mem_stall) begin
      forward_a_d = forward_a_q;
      forward_b_d = forward_b_q;
    end else begin
      if (ex_bubble) begin
        forward_a_d = FWD_RF;
        forward_b_d = FWD_RF;
      end
      // A flush coinciding with a load-use still counts the stall cycle.
      if (load_use && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  // Select and counter registers, aligned with the instruction in EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      forward_a_q <= FWD_RF;
      forward_b_q <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      forward_a_q <= forward_a_d;
      forward_b_q <= forward_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign forward_a = forward_a_q;
  assign forward_b = forward_b_q;
  assign stall_cnt = stall_cnt_q;

`ifdef FWD_WB_BYPASS_EN
  // Read-first register file: the ID operand must come from the WB write data.
  always_comb begin
    id_bypass_rs1 = id_use_rs1 && entry_writes(wb_q, id_rs1);
    id_bypass_rs2 = id_use_rs2 && entry_writes(wb_q, id_rs2);
  end
`else
  // Write-first register file already returns the WB data, so no bypass.
  always_comb begin
    id_bypass_rs1 = 1'b0;
    id_bypass_rs2 = 1'b0;
  end
`endif

  // Load flags of the older stages only matter for MEM/WB data selection outside this block.
  logic unused_shadow_bits;
  assign unused_shadow_bits = ^{mem_q.mr, wb_q};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed pipeline sequences plus random traffic.
// Latency: expectations are pushed when inputs are driven and popped by the monitor half a cycle later.
// Backpressure: exercises flush, load-use stall, mem_stall freeze and mid-run reset.
module tb_fwd_hazard_ctrl;

  localparam int RAW = 5;
  localparam int CW  = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           id_valid = 1'b0;
  logic [RAW-1:0] id_rs1 = '0;
  logic [RAW-1:0] id_rs2 = '0;
  logic           id_use_rs1 = 1'b0;
  logic           id_use_rs2 = 1'b0;
  logic [RAW-1:0] id_rd = '0;
  logic           id_reg_write = 1'b0;
  logic           id_mem_read = 1'b0;
  logic           flush = 1'b0;
  logic           mem_stall = 1'b0;
  logic [1:0]     forward_a;
  logic [1:0]     forward_b;
  logic           stall;
  logic [CW-1:0]  stall_cnt;
  logic           id_bypass_rs1;
  logic           id_bypass_rs2;

  fwd_hazard_ctrl #(.RA_W(RAW), .STALL_CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .flush         (flush),
    .mem_stall     (mem_stall),
    .forward_a     (forward_a),
    .forward_b     (forward_b),
    .stall         (stall),
    .stall_cnt     (stall_cnt),
    .id_bypass_rs1 (id_bypass_rs1),
    .id_bypass_rs2 (id_bypass_rs2)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: instructions flowing through EX/MEM/WB ----------------
  typedef struct {
    bit vld;
    int rd;
    bit rw;
    bit ld;
  } instr_t;

  instr_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  int     m_fa, m_fb, m_cnt;

  typedef struct {
    bit st;
    bit b1;
    bit b2;
    int fa;
    int fb;
    int cnt;
    string tag;
  } exp_t;

  exp_t sbq[$];

  function automatic bit produces(input int stage, input int r);
    return pipe[stage].vld && pipe[stage].rw && pipe[stage].rd == r && r != 0;
  endfunction

  // Nearest older producer wins: the one in EX will be in MEM (select 2), the one in MEM in WB (select 1).
  function automatic int want_sel(input bit u, input int r);
    if (!u) return 0;
    if (produces(0, r)) return 2;
    if (produces(1, r)) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
    m_fa = 0; m_fb = 0; m_cnt = 0;
  endtask

  // Drive one cycle of ID inputs, record the expected outputs, then advance the model.
  task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                      input int rd, input bit rw, input bit ld, input bit fl, input bit ms,
                      input string tag);
    exp_t e;
    bit   hz;
    int   na, nb;
    @(posedge clk); #1;
    reset_n = 1'b1;
    id_valid = v; id_rs1 = RAW'(rs1); id_rs2 = RAW'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = RAW'(rd);
    id_reg_write = rw; id_mem_read = ld; flush = fl; mem_stall = ms;
    hz = !ms && v && pipe[0].ld && ((u1 && produces(0, rs1)) || (u2 && produces(0, rs2)));
    e.st = hz;
`ifdef FWD_WB_BYPASS_EN
    e.b1 = u1 && produces(2, rs1);
    e.b2 = u2 && produces(2, rs2);
`else
    e.b1 = 0;
    e.b2 = 0;
`endif
    e.fa = m_fa; e.fb = m_fb; e.cnt = m_cnt; e.tag = tag;
    sbq.push_back(e);
    if (!ms) begin
      na = want_sel(u1, rs1);
      nb = want_sel(u2, rs2);
      if (hz && m_cnt < CMAX) m_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (fl || hz) begin
        pipe[0] = '{0, 0, 0, 0};
        m_fa = 0; m_fb = 0;
      end else begin
        pipe[0] = '{v, rd, rw, ld};
        m_fa = na; m_fb = nb;
      end
    end
  endtask

  // Shorthands for common instruction shapes.
  task automatic alu(input int rd, input int rs1, input int rs2, input string tag);
    step(1, rs1, rs2, 1, 1, rd, 1, 0, 0, 0, tag);
  endtask
  task automatic ld(input int rd, input int rs1, input string tag);
    step(1, rs1, 0, 1, 0, rd, 1, 1, 0, 0, tag);
  endtask
  task automatic nop(input string tag);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  // Asynchronous reset in the middle of a cycle: outputs must drop at once.
  task automatic mid_reset(input string tag);
    exp_t e;
    @(posedge clk); #1;
    reset_n = 1'b0;
    model_reset();
    e.st = 0; e.b1 = 0; e.b2 = 0; e.fa = 0; e.fb = 0; e.cnt = 0; e.tag = tag;
    sbq.push_back(e);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk({mon_e.tag, ".stall"},     int'(stall),         int'(mon_e.st));
      chk({mon_e.tag, ".forward_a"}, int'(forward_a),     mon_e.fa);
      chk({mon_e.tag, ".forward_b"}, int'(forward_b),     mon_e.fb);
      chk({mon_e.tag, ".stall_cnt"}, int'(stall_cnt),     mon_e.cnt);
      chk({mon_e.tag, ".bypass1"},   int'(id_bypass_rs1), int'(mon_e.b1));
      chk({mon_e.tag, ".bypass2"},   int'(id_bypass_rs2), int'(mon_e.b2));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.forward_a", int'(forward_a), 0);
    chk("reset.forward_b", int'(forward_b), 0);
    chk("reset.stall",     int'(stall), 0);
    chk("reset.stall_cnt", int'(stall_cnt), 0);
    chk("reset.bypass",    int'({id_bypass_rs1, id_bypass_rs2}), 0);

    // EX/MEM forward on back-to-back dependency.
    alu(5, 1, 2, "t1.add");
    alu(6, 5, 1, "t1.sub");
    nop("t1.sub_in_ex");

    // MEM/WB forward across one nop, then youngest producer wins.
    alu(5, 1, 2, "t2.add");
    nop("t2.nop");
    alu(7, 1, 5, "t2.or");
    alu(5, 1, 2, "t2.add_a");
    alu(5, 3, 4, "t2.add_b");
    alu(9, 5, 5, "t2.use");
    nop("t2.use_in_ex");

    // Load-use: one stall cycle, then MEM/WB forwarding on both sources.
    ld(8, 1, "t3.lw");
    alu(9, 8, 8, "t3.add_stall");
    alu(9, 8, 8, "t3.add_go");
    nop("t3.add_in_ex");

    // x0 never forwards and never stalls.
    alu(0, 1, 2, "t4.add_x0");
    alu(3, 0, 0, "t4.read_x0");
    ld(0, 1, "t4.lw_x0");
    alu(3, 0, 0, "t4.read_x0_after_lw");
    nop("t4.tail");

    // Load-use coinciding with flush: bubble, count once, no repeat stall.
    ld(10, 1, "t5.lw");
    step(1, 10, 2, 1, 1, 11, 1, 0, 1, 0, "t5.flush_stall");
    alu(12, 1, 2, "t5.redirect_target");
    // Freeze for 3 cycles with a load-use pending in ID.
    ld(13, 1, "t5.lw2");
    step(1, 13, 13, 1, 1, 14, 1, 0, 0, 1, "t5.freeze1");
    step(1, 13, 13, 1, 1, 14, 1, 0, 0, 1, "t5.freeze2");
    step(1, 13, 13, 1, 1, 14, 1, 0, 0, 1, "t5.freeze3");
    alu(14, 13, 13, "t5.stall_after_freeze");
    alu(14, 13, 13, "t5.go");
    nop("t5.tail");

    // Reset while a load-use stall is asserted.
    ld(12, 1, "t6.lw");
    alu(13, 12, 2, "t6.stalling");
    mid_reset("t6.reset");
    nop("t6.after_reset");

    // WB writing x3 while ID reads x3.
    alu(3, 1, 2, "t6.add_x3");
    nop("t6.nop1");
    nop("t6.nop2");
    step(1, 3, 3, 1, 0, 4, 1, 0, 0, 0, "t6.read_x3");
    nop("t6.tail");

    // Random traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 7) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, "rand");
      if ($urandom_range(0, 999) == 0) mid_reset("rand.reset");
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      chk("drain.pending", sbq.size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
